// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned MAX_SRC = 24;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned HOLD_W  = 8;

    localparam logic [SEL_W-1:0] SEL_NONE = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or after ptr, wrapping.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC = MAX_SRC
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    int unsigned idx;

    // Scan N_SRC positions starting at ptr; the first hit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold limit and one-cycle turnaround.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC    = 24,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [N_SRC-1:0] req,
    input  logic             xfer_release,
    output logic [N_SRC-1:0] grant,
    output logic             grant_valid,
    output logic [SEL_W-1:0] sel,
    output logic             timeout
);

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0]  winner;
    logic              found;
    logic              owner_req;
    logic              at_limit;

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    assign owner_req = |(req & grant);
    assign at_limit  = (hold_cnt == HOLD_W'(MAX_HOLD));

    // Arbitration FSM; grant, ptr, hold_cnt and timeout are all registered here.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= N_SRC'(1) << winner;
                        ptr      <= (winner == SEL_W'(N_SRC - 1)) ? '0 : winner + SEL_W'(1);
                        hold_cnt <= HOLD_W'(1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_release || !owner_req || at_limit) begin
                        grant    <= '0;
                        hold_cnt <= '0;
                        state    <= TURN;
                        // Only a forced revoke (owner still wants the bus) is a timeout.
                        timeout  <= at_limit && !xfer_release && owner_req;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Binary owner index decoded straight from the registered grant.
    always_comb begin
        sel = SEL_NONE;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks for bus_arbiter (N_SRC=24, MAX_HOLD=8).
module tb_bus_arbiter;

    localparam int unsigned N  = 24;
    localparam int unsigned MH = 8;

    logic          clock = 1'b0;
    logic          clear_n;
    logic [N-1:0]  req;
    logic          xfer_release;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [4:0]    sel;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] req;
        logic         rel;
        logic [N-1:0] grant;
        logic [4:0]   sel;
        logic         tmo;
    } vec_t;

    vec_t vecs [23];

    bus_arbiter #(
        .N_SRC    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .req          (req),
        .xfer_release (xfer_release),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .sel          (sel),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [N-1:0] eg, input logic [4:0] es,
                             input logic et);
        check({name, ".grant"}, 32'(grant), 32'(eg));
        check({name, ".sel"}, 32'(sel), 32'(es));
        check({name, ".valid"}, 32'(grant_valid), 32'(eg != '0));
        check({name, ".timeout"}, 32'(timeout), 32'(et));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req          = '0;
        xfer_release = 1'b0;
        clear_n      = 1'b0;
        step();
        #2;
        clear_n = 1'b1;
    endtask

    int     wait_cnt [N];
    logic   prev_valid;
    logic [4:0] exp_sel;
    logic [N-1:0] flip;
    int     max_wait;

    initial begin
        // Reset values.
        req          = '0;
        xfer_release = 1'b0;
        clear_n      = 1'b0;
        #3;
        check_out("reset", '0, 5'd31, 1'b0);
        do_reset();

        // Table: per-cycle inputs and expected registered outputs.
        vecs[0]  = '{24'h000000, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[1]  = '{24'h000004, 1'b0, 24'h000004, 5'd2,  1'b0};
        vecs[2]  = '{24'h000004, 1'b1, 24'h000000, 5'd31, 1'b0};
        vecs[3]  = '{24'h000005, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[4]  = '{24'h000005, 1'b0, 24'h000001, 5'd0,  1'b0};
        vecs[5]  = '{24'h000005, 1'b1, 24'h000000, 5'd31, 1'b0};
        vecs[6]  = '{24'h000005, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[7]  = '{24'h000005, 1'b0, 24'h000004, 5'd2,  1'b0};
        vecs[8]  = '{24'h000005, 1'b1, 24'h000000, 5'd31, 1'b0};
        vecs[9]  = '{24'h000005, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[10] = '{24'h000005, 1'b0, 24'h000001, 5'd0,  1'b0};
        vecs[11] = '{24'h000004, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[12] = '{24'h000004, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[13] = '{24'h000004, 1'b0, 24'h000004, 5'd2,  1'b0};
        vecs[14] = '{24'h000000, 1'b1, 24'h000000, 5'd31, 1'b0};
        vecs[15] = '{24'h000000, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[16] = '{24'h000000, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[17] = '{24'h800001, 1'b0, 24'h800000, 5'd23, 1'b0};
        vecs[18] = '{24'h800001, 1'b1, 24'h000000, 5'd31, 1'b0};
        vecs[19] = '{24'h800001, 1'b0, 24'h000000, 5'd31, 1'b0};
        vecs[20] = '{24'h800001, 1'b0, 24'h000001, 5'd0,  1'b0};
        vecs[21] = '{24'h800001, 1'b1, 24'h000000, 5'd31, 1'b0};
        vecs[22] = '{24'h000000, 1'b0, 24'h000000, 5'd31, 1'b0};

        for (int v = 0; v < 23; v++) begin
            req          = vecs[v].req;
            xfer_release = vecs[v].rel;
            step();
            check_out($sformatf("vec%0d", v), vecs[v].grant, vecs[v].sel, vecs[v].tmo);
        end

        // Hold limit: forced revoke with timeout, then a normal exit at the limit.
        do_reset();
        req = 24'h800000;
        for (int c = 1; c <= int'(MH); c++) begin
            step();
            check_out($sformatf("hold%0d", c), 24'h800000, 5'd23, 1'b0);
        end
        step();
        check_out("tmo_turn", '0, 5'd31, 1'b1);
        step();
        check_out("tmo_idle", '0, 5'd31, 1'b0);
        step();
        check_out("tmo_regrant", 24'h800000, 5'd23, 1'b0);
        for (int c = 2; c <= int'(MH); c++) step();
        xfer_release = 1'b1;
        step();
        check_out("limit_release", '0, 5'd31, 1'b0);
        xfer_release = 1'b0;
        req          = '0;
        step();
        step();

        // No preemption; the waiting source wins behind the advanced pointer.
        do_reset();
        req = 24'h000020;
        step();
        check_out("own5", 24'h000020, 5'd5, 1'b0);
        req = 24'h000028;
        step();
        check_out("nopre1", 24'h000020, 5'd5, 1'b0);
        step();
        check_out("nopre2", 24'h000020, 5'd5, 1'b0);
        xfer_release = 1'b1;
        step();
        check_out("rel5", '0, 5'd31, 1'b0);
        xfer_release = 1'b0;
        step();
        check_out("rel5_idle", '0, 5'd31, 1'b0);
        step();
        check_out("own3", 24'h000008, 5'd3, 1'b0);

        // Asynchronous reset mid-BUSY.
        do_reset();
        req = 24'h000080;
        step();
        check_out("own7", 24'h000080, 5'd7, 1'b0);
        #2;
        clear_n = 1'b0;
        #1;
        check_out("async_rst", '0, 5'd31, 1'b0);
        req = 24'h000202;
        #1;
        clear_n = 1'b1;
        step();
        check_out("post_rst", 24'h000002, 5'd1, 1'b0);
        req          = '0;
        xfer_release = 1'b1;
        step();
        xfer_release = 1'b0;
        step();

        // Random traffic: invariants and bounded waiting.
        do_reset();
        for (int i = 0; i < int'(N); i++) wait_cnt[i] = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            flip         = N'($urandom) & N'($urandom) & N'($urandom);
            req          = req ^ flip;
            xfer_release = ($urandom_range(3) == 0);
            for (int i = 0; i < int'(N); i++) if (!req[i]) wait_cnt[i] = 0;
            step();
            check("rnd.onehot", 32'((grant & (grant - N'(1))) == '0), 32'd1);
            exp_sel = 5'd31;
            for (int i = 0; i < int'(N); i++) if (grant[i]) exp_sel = 5'(i);
            check("rnd.sel", 32'(sel), 32'(exp_sel));
            check("rnd.valid", 32'(grant_valid), 32'(grant != '0));
            if ((grant != '0) && !prev_valid) begin
                max_wait = 0;
                for (int i = 0; i < int'(N); i++) begin
                    if (grant[i]) wait_cnt[i] = 0;
                    else if (req[i]) wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
                check("rnd.starve", 32'(max_wait <= int'(N)), 32'd1);
            end
            prev_valid = (grant != '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
